// File: rtl/parq_control.sv
// Parking-meter command side: coins -> saturating counter loads, prescaled ticks -> single decrements.
// Optional PARQ_WARN_EN adds a registered low-time 'warn' output. All outputs registered, one-cycle pulses.
module parq_control #(
  parameter int N             = 8,
  parameter int CLKS_PER_TICK = 50000000,
  parameter int COIN_A_VALUE  = 5,
  parameter int COIN_B_VALUE  = 10,
  parameter int MAX_TIME      = 255,
  parameter int WARN_THRESH   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coin_a,
  input  logic         coin_b,
  input  logic         cancel,
  input  logic [N-1:0] q,
  input  logic         min_tick,
  output logic         syn_clr,
  output logic         load,
  output logic         en,
  output logic         up,
  output logic [N-1:0] d,
  output logic         running,
`ifdef PARQ_WARN_EN
  output logic         warn,
`endif
  output logic         expired
);

  localparam int PW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [N+1:0] A_W   = (N+2)'(COIN_A_VALUE);
  localparam logic [N+1:0] B_W   = (N+2)'(COIN_B_VALUE);
  localparam logic [N+1:0] MAX_W = (N+2)'(MAX_TIME);
  localparam logic [PW-1:0] PS_LAST = PW'(CLKS_PER_TICK - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t        state;
  logic          coin_a_d1;
  logic          coin_b_d1;
  logic [N:0]    pending_add;
  logic [1:0]    inflight;
  logic [PW-1:0] prescaler;
  logic          dec_pending;

  logic [N+1:0]  evt_sum;
  logic [N+1:0]  add_sum;
  logic [N+1:0]  q_sum;
  logic [N:0]    pending_next;
  logic [N-1:0]  load_val;
  logic          load_issue;
  logic          dec_service;
  logic          terminal;

  assign up = 1'b0;

  always_comb begin
    evt_sum = '0;
    if (coin_a && !coin_a_d1) evt_sum = evt_sum + A_W;
    if (coin_b && !coin_b_d1) evt_sum = evt_sum + B_W;
    load_issue = (pending_add != '0) && (inflight == 2'd0);
    // A load consumes pending_add, so this cycle's coins start a fresh accumulation.
    add_sum = (load_issue ? '0 : {1'b0, pending_add}) + evt_sum;
    pending_next = (add_sum > MAX_W) ? MAX_W[N:0] : add_sum[N:0];
    q_sum = {2'b00, q} + {1'b0, pending_add};
    load_val = (q_sum > MAX_W) ? MAX_W[N-1:0] : q_sum[N-1:0];
    dec_service = dec_pending && (inflight == 2'd0) && !load_issue;
    terminal = (state == RUN) && (prescaler == PS_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      coin_a_d1   <= 1'b0;
      coin_b_d1   <= 1'b0;
      pending_add <= '0;
      inflight    <= 2'd0;
      prescaler   <= '0;
      dec_pending <= 1'b0;
      syn_clr     <= 1'b0;
      load        <= 1'b0;
      en          <= 1'b0;
      d           <= '0;
      running     <= 1'b0;
      expired     <= 1'b0;
`ifdef PARQ_WARN_EN
      warn        <= 1'b0;
`endif
    end else begin
      coin_a_d1 <= coin_a;
      coin_b_d1 <= coin_b;
      syn_clr   <= 1'b0;
      load      <= 1'b0;
      en        <= 1'b0;
      if (inflight != 2'd0) inflight <= inflight - 2'd1;
`ifdef PARQ_WARN_EN
      warn <= (state == RUN) && (q <= N'(WARN_THRESH));
`endif
      if (cancel) begin
        syn_clr     <= 1'b1;
        pending_add <= '0;
        dec_pending <= 1'b0;
        prescaler   <= '0;
        inflight    <= 2'd2;
        state       <= IDLE;
        running     <= 1'b0;
        expired     <= 1'b0;
      end else begin
        pending_add <= pending_next;
        if (load_issue) begin
          load     <= 1'b1;
          d        <= load_val;
          inflight <= 2'd2;
        end else if (dec_service && (q != '0)) begin
          // Hold off a load until the decrement has landed in q.
          en       <= 1'b1;
          inflight <= 2'd1;
        end
        // A new tick arriving as the old one is serviced must not be lost.
        if (terminal) dec_pending <= 1'b1;
        else if (dec_service) dec_pending <= 1'b0;
        case (state)
          RUN: begin
            if (min_tick && (inflight == 2'd0) && (pending_add == '0)) begin
              state       <= EXPIRED;
              running     <= 1'b0;
              expired     <= 1'b1;
              dec_pending <= 1'b0;
              prescaler   <= '0;
            end else begin
              prescaler <= terminal ? '0 : prescaler + 1'b1;
            end
          end
          default: begin
            prescaler <= '0;
            if ((inflight == 2'd0) && (q != '0)) begin
              state   <= RUN;
              running <= 1'b1;
              expired <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parq_control.sv
// Directed bench for parq_control driving a behavioural up/down counter.
module tb_parq_control;

  logic       clk = 1'b0;
  logic       reset, coin_a, coin_b, cancel;
  logic [7:0] q, d;
  logic       min_tick, syn_clr, load, en, up, running, expired;
`ifdef PARQ_WARN_EN
  logic       warn;
`endif

  int checks = 0;
  int failures = 0;
  int multi_hot = 0;

  always #5 clk = ~clk;

  parq_control #(.N(8), .CLKS_PER_TICK(4), .COIN_A_VALUE(5), .COIN_B_VALUE(10),
                 .MAX_TIME(20), .WARN_THRESH(3)) dut (
    .clk(clk), .reset(reset), .coin_a(coin_a), .coin_b(coin_b), .cancel(cancel),
    .q(q), .min_tick(min_tick), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .running(running),
`ifdef PARQ_WARN_EN
    .warn(warn),
`endif
    .expired(expired));

  always @(posedge clk) begin
    if (reset)        q <= 8'd0;
    else if (syn_clr) q <= 8'd0;
    else if (load)    q <= d;
    else if (en)      q <= up ? q + 8'd1 : q - 8'd1;
  end
  assign min_tick = (q == 8'd0);

  always @(negedge clk)
    if (int'(syn_clr) + int'(load) + int'(en) > 1) multi_hot++;

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; coin_a = 1'b0; coin_b = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if ({syn_clr, load, en, up} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b want=0000", {syn_clr, load, en, up}); end
    checks++; if (d !== 8'd0) begin failures++; $display("FAIL reset_d got=%0d want=0", d); end
    checks++; if ({running, expired} !== 2'b00) begin failures++; $display("FAIL reset_state got=%b want=00", {running, expired}); end
  endtask

  task automatic test_single_coin;
    int cyc = 0, load_cnt = 0, load_cyc = -1, run_cyc = -1, en_cnt = 0, last_en = -1, gap_bad = 0;
    logic [7:0] load_d = 8'd0;
    apply_reset();
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    while (!expired && cyc < 100) begin
      @(negedge clk); cyc++;
      if (load) begin load_cnt++; load_d = d; load_cyc = cyc; end
      if (running && run_cyc < 0) run_cyc = cyc;
      if (en) begin
        if (last_en >= 0 && cyc - last_en != 4) gap_bad++;
        last_en = cyc; en_cnt++;
      end
    end
    checks++; if (!expired) begin failures++; $display("FAIL single_timeout expired=%b want=1 after %0d cycles", expired, cyc); end
    checks++; if (load_cnt != 1 || load_d !== 8'd5) begin failures++; $display("FAIL single_load count=%0d d=%0d want 1/5", load_cnt, load_d); end
    checks++; if (run_cyc <= load_cyc || run_cyc - load_cyc > 4) begin failures++; $display("FAIL single_run_latency got=%0d want 1..4", run_cyc - load_cyc); end
    checks++; if (en_cnt != 5 || gap_bad != 0) begin failures++; $display("FAIL single_decrements en=%0d bad_gaps=%0d want 5/0", en_cnt, gap_bad); end
    checks++; if (q !== 8'd0 || running !== 1'b0) begin failures++; $display("FAIL single_end q=%0d running=%b want 0/0", q, running); end
    en_cnt = 0;
    repeat (12) begin @(negedge clk); if (en) en_cnt++; end
    checks++; if (en_cnt != 0 || expired !== 1'b1) begin failures++; $display("FAIL single_after_expiry en=%0d expired=%b want 0/1", en_cnt, expired); end
  endtask

  task automatic test_both_coins;
    bit found = 0;
    logic [7:0] got = 8'd0;
    apply_reset();
    coin_a = 1'b1; coin_b = 1'b1;
    @(negedge clk); coin_a = 1'b0; coin_b = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (load) begin found = 1; got = d; end
    end
    checks++; if (!found || got !== 8'd15) begin failures++; $display("FAIL both_coins found=%b d=%0d want 1/15", found, got); end
    @(negedge clk);
    checks++; if (q !== 8'd15) begin failures++; $display("FAIL both_coins_q got=%0d want=15", q); end
  endtask

  task automatic test_back_to_back;
    int load_cnt = 0, first_cyc = -1, second_cyc = -1;
    logic [7:0] d0 = 8'd0, d1 = 8'd0;
    bit found = 0;
    logic [7:0] got = 8'd0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      coin_a = (i == 0 || i == 2);
      coin_b = (i == 1);
      @(negedge clk);
      if (load) begin
        if (load_cnt == 0) begin d0 = d; first_cyc = i; end
        else begin d1 = d; second_cyc = i; end
        load_cnt++;
      end
    end
    checks++; if (load_cnt != 2 || d0 !== 8'd5 || d1 !== 8'd20) begin failures++; $display("FAIL b2b_loads count=%0d d0=%0d d1=%0d want 2/5/20", load_cnt, d0, d1); end
    checks++; if (second_cyc - first_cyc < 2) begin failures++; $display("FAIL b2b_spacing got=%0d want>=2", second_cyc - first_cyc); end
    checks++; if (q !== 8'd20) begin failures++; $display("FAIL b2b_final_q got=%0d want=20", q); end
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (load) begin found = 1; got = d; end
    end
    checks++; if (!found || got !== 8'd20) begin failures++; $display("FAIL saturate_at_max found=%b d=%0d want 1/20", found, got); end
  endtask

  task automatic test_coin_at_terminal;
    bit found = 0;
    logic [7:0] qv [8];
    logic ev [8];
    logic lv [8];
    logic [7:0] ld = 8'd0;
    int early_en = 0;
    apply_reset();
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (running) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL term_run_timeout running=%b want=1", running); end
    repeat (3) @(negedge clk);
    checks++; if (q !== 8'd5) begin failures++; $display("FAIL term_q_before got=%0d want=5", q); end
    coin_b = 1'b1;
    @(negedge clk); coin_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      qv[i] = q; ev[i] = en; lv[i] = load;
      if (load) ld = d;
      if (i < 4 && en) early_en++;
      @(negedge clk);
    end
    checks++; if (lv[1] !== 1'b1 || ld !== 8'd15) begin failures++; $display("FAIL term_load load=%b d=%0d want 1/15", lv[1], ld); end
    checks++; if (early_en != 0 || qv[2] !== 8'd15) begin failures++; $display("FAIL term_load_first early_en=%0d q=%0d want 0/15", early_en, qv[2]); end
    checks++; if (ev[4] !== 1'b1 || qv[5] !== 8'd14) begin failures++; $display("FAIL term_deferred_dec en=%b q=%0d want 1/14", ev[4], qv[5]); end
    checks++; if (ev[6] !== 1'b1 || qv[7] !== 8'd13) begin failures++; $display("FAIL term_next_dec en=%b q=%0d want 1/13", ev[6], qv[7]); end
  endtask

  task automatic test_cancel;
    bit found = 0;
    int en_cnt = 0, load_cnt = 0;
    apply_reset();
    coin_a = 1'b1; coin_b = 1'b1;
    @(negedge clk); coin_a = 1'b0; coin_b = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (q == 8'd12) found = 1;
    end
    checks++; if (!found || running !== 1'b1) begin failures++; $display("FAIL cancel_setup found=%b running=%b want 1/1", found, running); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    checks++; if (syn_clr !== 1'b1 || running !== 1'b0 || expired !== 1'b0) begin failures++; $display("FAIL cancel_pulse syn_clr=%b running=%b expired=%b want 1/0/0", syn_clr, running, expired); end
    @(negedge clk);
    checks++; if (syn_clr !== 1'b0 || q !== 8'd0) begin failures++; $display("FAIL cancel_cleared syn_clr=%b q=%0d want 0/0", syn_clr, q); end
    repeat (20) begin @(negedge clk); if (en) en_cnt++; if (load) load_cnt++; end
    checks++; if (en_cnt != 0 || load_cnt != 0 || running !== 1'b0 || expired !== 1'b0) begin failures++; $display("FAIL cancel_quiet en=%0d load=%0d running=%b expired=%b want 0/0/0/0", en_cnt, load_cnt, running, expired); end
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (load) found = 1;
    end
    @(negedge clk);
    checks++; if (!found || q !== 8'd5) begin failures++; $display("FAIL cancel_recoin found=%b q=%0d want 1/5", found, q); end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    int load_cnt = 0;
    apply_reset();
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (load) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_setup load=%b want=1", load); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({syn_clr, load, en} !== 3'b0 || d !== 8'd0) begin failures++; $display("FAIL rstmid_outputs pulses=%b d=%0d want 000/0", {syn_clr, load, en}, d); end
    checks++; if ({running, expired} !== 2'b00 || q !== 8'd0) begin failures++; $display("FAIL rstmid_state run_exp=%b q=%0d want 00/0", {running, expired}, q); end
    reset = 1'b0;
    repeat (10) begin @(negedge clk); if (load) load_cnt++; end
    checks++; if (load_cnt != 0 || running !== 1'b0) begin failures++; $display("FAIL rstmid_quiet load=%0d running=%b want 0/0", load_cnt, running); end
  endtask

`ifdef PARQ_WARN_EN
  task automatic test_warn;
    bit found = 0;
    apply_reset();
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (running && q == 8'd3) found = 1;
    end
    @(negedge clk);
    checks++; if (!found || warn !== 1'b1) begin failures++; $display("FAIL warn_rise found=%b warn=%b want 1/1", found, warn); end
    coin_a = 1'b1;
    @(negedge clk); coin_a = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (q > 8'd3) found = 1;
    end
    @(negedge clk);
    checks++; if (!found || warn !== 1'b0) begin failures++; $display("FAIL warn_fall_coin found=%b warn=%b want 1/0", found, warn); end
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (expired) found = 1;
    end
    @(negedge clk);
    checks++; if (!found || warn !== 1'b0) begin failures++; $display("FAIL warn_fall_expiry found=%b warn=%b want 1/0", found, warn); end
  endtask
`endif

  task automatic test_exclusive;
    checks++; if (multi_hot != 0) begin failures++; $display("FAIL pulse_exclusive cycles=%0d want=0", multi_hot); end
  endtask

  initial begin
    reset = 1'b1; coin_a = 1'b0; coin_b = 1'b0; cancel = 1'b0;
    test_reset();
    test_single_coin();
    test_both_coins();
    test_back_to_back();
    test_coin_at_terminal();
    test_cancel();
    test_reset_mid();
`ifdef PARQ_WARN_EN
    test_warn();
`endif
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
